// File: rtl/spawn_pkg.sv
// Shared types and width helpers for the spawn controller and its modulo units.
package spawn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REDUCE = 2'd1,
    ST_OFFER  = 2'd2
  } state_e;

  localparam int DROP_W = 8;
  localparam int RAND_W = 8;

  // Index/coordinate width for n values, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spawn_mod_reduce.sv
// Iterative subtract-modulo unit: loads a value on start, then subtracts LIMIT
// once per cycle until the remainder is below LIMIT.
module spawn_mod_reduce
  import spawn_pkg::*;
#(
  parameter int LIMIT = 20,
  parameter int OW    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [RAND_W-1:0] value,
  output logic              done,
  output logic [OW-1:0]     result
);

  localparam logic [RAND_W-1:0] LIM = RAND_W'(LIMIT);

  logic [RAND_W-1:0] rem_q;
  logic [RAND_W-1:0] rem_d;

  // Next remainder: load, subtract one step, or hold once in range.
  always_comb begin
    rem_d = rem_q;
    if (start) begin
      rem_d = value;
    end else if (rem_q >= LIM) begin
      rem_d = rem_q - LIM;
    end else begin
      rem_d = rem_q;
    end
  end

  // Remainder register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
    end else begin
      rem_q <= rem_d;
    end
  end

  assign done   = (rem_q < LIM);
  assign result = rem_q[OW-1:0];

endmodule

// File: rtl/spawn_ctrl.sv
// Spawn controller: periodic timer, random coordinate reduction, lowest-free
// slot reservation and a valid/ready spawn offer with slot tracking.
module spawn_ctrl
  import spawn_pkg::*;
#(
  parameter int N_SLOTS  = 6,
  parameter int X_CELLS  = 20,
  parameter int Y_CELLS  = 15,
  parameter int INTERVAL = 60
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  input  logic                              tick,
  input  logic [RAND_W-1:0]                 rand_x,
  input  logic [RAND_W-1:0]                 rand_y,
  input  logic                              kill_valid,
  input  logic [clog2_min1(N_SLOTS)-1:0]    kill_idx,
  output logic                              spawn_valid,
  input  logic                              spawn_ready,
  output logic [clog2_min1(N_SLOTS)-1:0]    spawn_idx,
  output logic [clog2_min1(X_CELLS)-1:0]    spawn_x,
  output logic [clog2_min1(Y_CELLS)-1:0]    spawn_y,
  output logic [N_SLOTS-1:0]                active_mask,
  output logic [DROP_W-1:0]                 drop_cnt
);

  localparam int IW = clog2_min1(N_SLOTS);
  localparam int XW = clog2_min1(X_CELLS);
  localparam int YW = clog2_min1(Y_CELLS);
  localparam int CW = clog2_min1(INTERVAL);
  localparam logic [CW-1:0] CNT_RELOAD = CW'(INTERVAL - 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               spawn_valid_q, spawn_valid_d;
  logic [IW-1:0]      spawn_idx_q, spawn_idx_d;
  logic [N_SLOTS-1:0] active_mask_q, active_mask_d;
  logic [DROP_W-1:0]  drop_cnt_q, drop_cnt_d;

  logic               expire;
  logic               free_found;
  logic [IW-1:0]      free_idx;
  logic               start_req;
  logic               accept;
  logic               drop;
  logic               kill_in_range;
  logic               x_done, y_done;
  logic [N_SLOTS-1:0] kill_vec, set_vec;

  // Interval timer: counts enabled ticks and pulses expire on the reload tick.
  always_comb begin
    cnt_d  = cnt_q;
    expire = 1'b0;
    if (tick && enable) begin
      if (cnt_q == '0) begin
        cnt_d  = CNT_RELOAD;
        expire = 1'b1;
      end else begin
        cnt_d  = cnt_q - CW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Lowest free slot; scanning downward lets the lowest index win.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      free_found = free_found | ~active_mask_q[i];
      free_idx   = active_mask_q[i] ? free_idx : IW'(i);
    end
  end

  assign start_req     = (state_q == ST_IDLE) && expire && free_found;
  assign accept        = (state_q == ST_OFFER) && spawn_ready;
  assign drop          = expire && ((state_q != ST_IDLE) || !free_found);
  assign kill_in_range = ({1'b0, kill_idx} < (IW + 1)'(N_SLOTS));

  spawn_mod_reduce #(.LIMIT(X_CELLS), .OW(XW)) u_red_x (
    .clk    (clk),
    .rst    (rst),
    .start  (start_req),
    .value  (rand_x),
    .done   (x_done),
    .result (spawn_x)
  );

  spawn_mod_reduce #(.LIMIT(Y_CELLS), .OW(YW)) u_red_y (
    .clk    (clk),
    .rst    (rst),
    .start  (start_req),
    .value  (rand_y),
    .done   (y_done),
    .result (spawn_y)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; REDUCE waits until both coordinates are in range.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = start_req ? ST_REDUCE : ST_IDLE;
      ST_REDUCE: state_d = (x_done && y_done) ? ST_OFFER : ST_REDUCE;
      ST_OFFER:  state_d = spawn_ready ? ST_IDLE : ST_OFFER;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs and slot bookkeeping; an accept overrides a same-slot kill.
  always_comb begin
    spawn_valid_d = (state_d == ST_OFFER);
    spawn_idx_d   = start_req ? free_idx : spawn_idx_q;
    if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + DROP_W'(1);
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
    kill_vec = '0;
    set_vec  = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      kill_vec[i] = kill_valid && kill_in_range && (kill_idx == IW'(i));
      set_vec[i]  = accept && (spawn_idx_q == IW'(i));
    end
    active_mask_d = set_vec | (active_mask_q & ~kill_vec);
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= CNT_RELOAD;
      spawn_valid_q <= 1'b0;
      spawn_idx_q   <= '0;
      active_mask_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      cnt_q         <= cnt_d;
      spawn_valid_q <= spawn_valid_d;
      spawn_idx_q   <= spawn_idx_d;
      active_mask_q <= active_mask_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign spawn_valid = spawn_valid_q;
  assign spawn_idx   = spawn_idx_q;
  assign active_mask = active_mask_q;
  assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_spawn_ctrl.sv
// Scoreboard bench for spawn_ctrl: expected spawns are queued when an expiry
// is driven and compared when the offer appears.
module tb_spawn_ctrl;

  localparam int N_SLOTS  = 6;
  localparam int X_CELLS  = 20;
  localparam int Y_CELLS  = 15;
  localparam int INTERVAL = 4;

  logic       clk = 1'b0;
  logic       rst, enable, tick, kill_valid, spawn_ready, spawn_valid;
  logic [7:0] rand_x, rand_y;
  logic [2:0] kill_idx, spawn_idx;
  logic [4:0] spawn_x;
  logic [3:0] spawn_y;
  logic [5:0] active_mask;
  logic [7:0] drop_cnt;

  typedef struct {
    logic [2:0] idx;
    logic [4:0] x;
    logic [3:0] y;
    int         lat;
  } exp_t;

  exp_t       sb_q[$];
  logic [5:0] exp_mask;
  int         exp_drop;
  logic       busy;
  int         errors = 0;
  int         checks = 0;

  spawn_ctrl #(.N_SLOTS(N_SLOTS), .X_CELLS(X_CELLS), .Y_CELLS(Y_CELLS), .INTERVAL(INTERVAL)) dut (
    .clk(clk), .rst(rst), .enable(enable), .tick(tick),
    .rand_x(rand_x), .rand_y(rand_y),
    .kill_valid(kill_valid), .kill_idx(kill_idx),
    .spawn_valid(spawn_valid), .spawn_ready(spawn_ready),
    .spawn_idx(spawn_idx), .spawn_x(spawn_x), .spawn_y(spawn_y),
    .active_mask(active_mask), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      step();
    end
    tick = 1'b0;
  endtask

  function automatic exp_t make_exp(input logic [7:0] rx, input logic [7:0] ry);
    exp_t e;
    int qx, qy;
    e.idx = 3'd0;
    for (int i = N_SLOTS - 1; i >= 0; i--) if (!exp_mask[i]) e.idx = 3'(i);
    e.x = 5'(int'(rx) % X_CELLS);
    e.y = 4'(int'(ry) % Y_CELLS);
    qx = int'(rx) / X_CELLS;
    qy = int'(ry) / Y_CELLS;
    e.lat = ((qx > qy) ? qx : qy) + 1;
    return e;
  endfunction

  // One full interval of ticks; queues a spawn or counts a drop.
  task automatic issue(input logic [7:0] rx, input logic [7:0] ry);
    rand_x = rx;
    rand_y = ry;
    if (!busy && exp_mask != 6'b111111) begin
      sb_q.push_back(make_exp(rx, ry));
      busy = 1'b1;
    end else if (exp_drop < 255) begin
      exp_drop++;
    end
    pulse_ticks(INTERVAL);
  endtask

  task automatic wait_offer(output exp_t e);
    int cyc;
    e = sb_q.pop_front();
    cyc = 0;
    while (spawn_valid !== 1'b1 && cyc < 400) begin
      step();
      cyc++;
    end
    if (spawn_valid !== 1'b1) cyc = -1;
    checks++;
    if (cyc !== e.lat) begin
      errors++;
      $display("FAIL reduce_latency: got %0d cycles, expected %0d", cyc, e.lat);
    end
    checks++;
    if (spawn_idx !== e.idx || spawn_x !== e.x || spawn_y !== e.y) begin
      errors++;
      $display("FAIL offer_fields: idx/x/y got %0d/%0d/%0d, expected %0d/%0d/%0d",
               spawn_idx, spawn_x, spawn_y, e.idx, e.x, e.y);
    end
    checks++;
    if (active_mask !== exp_mask) begin
      errors++;
      $display("FAIL reserved_not_active: mask got %b, expected %b", active_mask, exp_mask);
    end
  endtask

  task automatic accept_offer(input exp_t e, input logic do_kill, input logic [2:0] kidx);
    spawn_ready = 1'b1;
    kill_valid  = do_kill;
    kill_idx    = kidx;
    step();
    spawn_ready = 1'b0;
    kill_valid  = 1'b0;
    if (do_kill && int'(kidx) < N_SLOTS) exp_mask[kidx] = 1'b0;
    exp_mask[e.idx] = 1'b1;
    busy = 1'b0;
    checks++;
    if (spawn_valid !== 1'b0) begin
      errors++;
      $display("FAIL accept_valid_clear: got %b, expected 0", spawn_valid);
    end
    checks++;
    if (active_mask !== exp_mask) begin
      errors++;
      $display("FAIL accept_mask: got %b, expected %b", active_mask, exp_mask);
    end
  endtask

  task automatic kill(input logic [2:0] k);
    kill_valid = 1'b1;
    kill_idx   = k;
    step();
    kill_valid = 1'b0;
    if (int'(k) < N_SLOTS) exp_mask[k] = 1'b0;
    checks++;
    if (active_mask !== exp_mask) begin
      errors++;
      $display("FAIL kill_mask idx=%0d: got %b, expected %b", k, active_mask, exp_mask);
    end
  endtask

  task automatic model_reset();
    sb_q.delete();
    exp_mask = 6'b0;
    exp_drop = 0;
    busy     = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; tick = 1'b0; kill_valid = 1'b0; kill_idx = 3'd0;
    spawn_ready = 1'b0; rand_x = 8'd0; rand_y = 8'd0;
    step(); step();
    rst = 1'b0;
    model_reset();
    checks++;
    if (spawn_valid !== 1'b0 || spawn_idx !== 3'd0 || spawn_x !== 5'd0 || spawn_y !== 4'd0) begin
      errors++;
      $display("FAIL reset_outputs: valid/idx/x/y got %b/%0d/%0d/%0d, expected 0/0/0/0",
               spawn_valid, spawn_idx, spawn_x, spawn_y);
    end
    checks++;
    if (active_mask !== 6'b0 || drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: mask/drop got %b/%0d, expected 000000/0", active_mask, drop_cnt);
    end
    // Ticks with enable low must not advance the timer.
    pulse_ticks(10);
    repeat (5) step();
    checks++;
    if (spawn_valid !== 1'b0) begin
      errors++;
      $display("FAIL disabled_timer: spawn_valid got %b, expected 0", spawn_valid);
    end
    enable = 1'b1;
  endtask

  task automatic test_basic();
    exp_t e;
    issue(8'd47, 8'd47);
    wait_offer(e);
    accept_offer(e, 1'b0, 3'd0);
  endtask

  task automatic test_long_reduce();
    exp_t e;
    issue(8'd200, 8'd200);
    wait_offer(e);
    for (int i = 0; i < 20; i++) begin
      rand_x = 8'($urandom);
      rand_y = 8'($urandom);
      step();
      checks++;
      if (spawn_valid !== 1'b1 || spawn_idx !== e.idx || spawn_x !== e.x || spawn_y !== e.y) begin
        errors++;
        $display("FAIL offer_hold cyc=%0d: valid/idx/x/y got %b/%0d/%0d/%0d, expected 1/%0d/%0d/%0d",
                 i, spawn_valid, spawn_idx, spawn_x, spawn_y, e.idx, e.x, e.y);
      end
    end
    issue(8'd1, 8'd2);
    issue(8'd3, 8'd4);
    checks++;
    if (drop_cnt !== 8'(exp_drop)) begin
      errors++;
      $display("FAIL busy_drops: got %0d, expected %0d", drop_cnt, exp_drop);
    end
    checks++;
    if (spawn_valid !== 1'b1 || spawn_idx !== e.idx || spawn_x !== e.x || spawn_y !== e.y) begin
      errors++;
      $display("FAIL offer_after_drops: valid/idx/x/y got %b/%0d/%0d/%0d, expected 1/%0d/%0d/%0d",
               spawn_valid, spawn_idx, spawn_x, spawn_y, e.idx, e.x, e.y);
    end
    accept_offer(e, 1'b0, 3'd0);
  endtask

  task automatic test_full();
    exp_t e;
    logic seen;
    for (int k = 0; k < 4; k++) begin
      issue(8'($urandom), 8'($urandom));
      wait_offer(e);
      accept_offer(e, 1'b0, 3'd0);
    end
    issue(8'd5, 8'd5);
    checks++;
    if (drop_cnt !== 8'(exp_drop)) begin
      errors++;
      $display("FAIL full_drop: got %0d, expected %0d", drop_cnt, exp_drop);
    end
    seen = 1'b0;
    repeat (20) begin
      step();
      seen = seen | spawn_valid;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL full_no_offer: spawn_valid seen %b, expected 0", seen);
    end
    kill(3'd3);
    issue(8'd100, 8'd30);
    wait_offer(e);
    accept_offer(e, 1'b0, 3'd0);
  endtask

  task automatic test_kill_accept();
    exp_t e;
    kill(3'd2);
    issue(8'd19, 8'd14);
    wait_offer(e);
    accept_offer(e, 1'b1, 3'd2);
    kill(3'd7);
    kill(3'd6);
  endtask

  task automatic test_reset_offer();
    exp_t e;
    logic seen;
    kill(3'd0);
    issue(8'd60, 8'd60);
    wait_offer(e);
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    checks++;
    if (spawn_valid !== 1'b0 || active_mask !== 6'b0 || drop_cnt !== 8'd0 || spawn_x !== 5'd0) begin
      errors++;
      $display("FAIL reset_in_offer: valid/mask/drop/x got %b/%b/%0d/%0d, expected 0/000000/0/0",
               spawn_valid, active_mask, drop_cnt, spawn_x);
    end
    pulse_ticks(INTERVAL - 1);
    seen = 1'b0;
    repeat (10) begin
      step();
      seen = seen | spawn_valid;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL early_spawn: spawn_valid seen %b before interval, expected 0", seen);
    end
    rand_x = 8'd47;
    rand_y = 8'd47;
    sb_q.push_back(make_exp(8'd47, 8'd47));
    busy = 1'b1;
    pulse_ticks(1);
    wait_offer(e);
    accept_offer(e, 1'b0, 3'd0);
  endtask

  task automatic test_saturate();
    exp_t e;
    issue(8'd10, 8'd10);
    wait_offer(e);
    for (int i = 0; i < 300; i++) begin
      issue(8'($urandom), 8'($urandom));
      if (i == 99) begin
        checks++;
        if (drop_cnt !== 8'(exp_drop)) begin
          errors++;
          $display("FAIL drop_count_mid: got %0d, expected %0d", drop_cnt, exp_drop);
        end
      end
    end
    checks++;
    if (drop_cnt !== 8'd255) begin
      errors++;
      $display("FAIL drop_saturate: got %0d, expected 255", drop_cnt);
    end
    accept_offer(e, 1'b0, 3'd0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_long_reduce();
    test_full();
    test_kill_accept();
    test_reset_offer();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
